// File: rtl/nco_capture_writer.sv
// nco_capture_writer: serialises multi-channel NCO beats into 32-bit samples,
// packs sample pairs into 64-bit words and writes them into the second port of
// an on-chip memory as a one-shot or ring capture buffer.
module nco_capture_writer #(
  parameter int NUM_CH    = 2,
  parameter int SAMPLE_W  = 36,
  parameter int ADDR_W    = 14,
  parameter int CAP_WORDS = 1024
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic [NUM_CH*SAMPLE_W-1:0] in_data,
  input  logic                       in_valid,
  input  logic                       cfg_arm,
  input  logic                       cfg_stop,
  input  logic                       cfg_trig_imm,
  input  logic                       cfg_continuous,
  input  logic                       trig_in,
  output logic [ADDR_W-1:0]          mem_address,
  output logic                       mem_chipselect,
  output logic                       mem_clken,
  output logic                       mem_write,
  output logic [63:0]                mem_writedata,
  output logic [7:0]                 mem_byteenable,
  output logic                       st_busy,
  output logic                       st_done,
  output logic                       st_overrun,
  output logic                       st_wrapped,
  output logic [ADDR_W:0]            st_words
);

  localparam int                CW         = $clog2(NUM_CH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(CAP_WORDS - 1);
  localparam logic [ADDR_W:0]   FULL_WORDS = (ADDR_W + 1)'(CAP_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_e;

  state_e                state_q, state_d;
  logic                  trig_prev_q, trig_prev_d;
  logic [NUM_CH*32-1:0]  beat_q, beat_d, beat_mapped;
  logic [CW-1:0]         ser_left_q, ser_left_d;
  logic                  half_q, half_d;
  logic [31:0]           lo_q, lo_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic                  wr_q, wr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [7:0]            be_q, be_d;
  logic                  overrun_q, overrun_d;
  logic                  wrapped_q, wrapped_d;
  logic [ADDR_W:0]       words_q, words_d;
  logic                  do_wr;
  logic [63:0]           wr_data;
  logic [7:0]            wr_be;

  // Map each channel to a 32-bit sample: keep the top 32 bits of wide samples,
  // sign-extend narrow ones.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_map
    logic [SAMPLE_W-1:0] raw;
    assign raw = in_data[k*SAMPLE_W +: SAMPLE_W];
    if (SAMPLE_W >= 32) begin : g_upper
      assign beat_mapped[k*32 +: 32] = raw[SAMPLE_W-1 -: 32];
      if (SAMPLE_W > 32) begin : g_low
        logic unused_low;
        assign unused_low = ^raw[SAMPLE_W-33:0];
      end
    end else begin : g_sext
      assign beat_mapped[k*32 +: 32] = {{(32 - SAMPLE_W){raw[SAMPLE_W-1]}}, raw};
    end
  end

  // Next-state logic: capture FSM, serialiser, pair packer and write strobe.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    trig_prev_d = trig_in;
    beat_d      = beat_q;
    ser_left_d  = ser_left_q;
    half_d      = half_q;
    lo_d        = lo_q;
    wr_ptr_d    = wr_ptr_q;
    wr_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    overrun_d   = overrun_q;
    wrapped_d   = wrapped_q;
    words_d     = words_q;
    do_wr       = 1'b0;
    wr_data     = '0;
    wr_be       = 8'hFF;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (cfg_arm) begin
          state_d    = cfg_trig_imm ? S_CAPTURE : S_ARMED;
          ser_left_d = '0;
          half_d     = 1'b0;
          wr_ptr_d   = '0;
          words_d    = '0;
          overrun_d  = 1'b0;
          wrapped_d  = 1'b0;
        end
      end
      S_ARMED: begin
        if (cfg_stop) begin
          state_d = S_DONE;
        end else if (cfg_trig_imm || (trig_in && !trig_prev_q)) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // Emit one sample per cycle, ch0 first; the second of a pair completes a word.
        if (ser_left_q != '0) begin
          ser_left_d = ser_left_q - CW'(1);
          beat_d     = beat_q >> 32;
          if (half_q) begin
            do_wr   = 1'b1;
            wr_data = {beat_q[31:0], lo_q};
            half_d  = 1'b0;
          end else if (!cfg_stop) begin
            lo_d   = beat_q[31:0];
            half_d = 1'b1;
          end
        end
        // Stop flushes a lone half pair unless a full word is already going out.
        if (cfg_stop) begin
          state_d = S_DONE;
          if (!do_wr && half_q) begin
            do_wr   = 1'b1;
            wr_data = {32'h0, lo_q};
            wr_be   = 8'h0F;
            half_d  = 1'b0;
          end
        end
        if (do_wr) begin
          wr_d    = 1'b1;
          addr_d  = wr_ptr_q;
          wdata_d = wr_data;
          be_d    = wr_be;
          if (words_q != FULL_WORDS) words_d = words_q + (ADDR_W + 1)'(1);
          if (wr_ptr_q == LAST_ADDR) begin
            wr_ptr_d = '0;
            if (cfg_continuous) wrapped_d = 1'b1;
            else                state_d   = S_DONE;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
        // Accept a beat when the serialiser is idle or on its last emit cycle.
        if (in_valid && !cfg_stop && state_d == S_CAPTURE) begin
          if (ser_left_q <= CW'(1)) begin
            beat_d     = beat_mapped;
            ser_left_d = CW'(NUM_CH);
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset_reset) begin
      state_q     <= S_IDLE;
      trig_prev_q <= 1'b0;
      beat_q      <= '0;
      ser_left_q  <= '0;
      half_q      <= 1'b0;
      lo_q        <= '0;
      wr_ptr_q    <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      overrun_q   <= 1'b0;
      wrapped_q   <= 1'b0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      trig_prev_q <= trig_prev_d;
      beat_q      <= beat_d;
      ser_left_q  <= ser_left_d;
      half_q      <= half_d;
      lo_q        <= lo_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      overrun_q   <= overrun_d;
      wrapped_q   <= wrapped_d;
      words_q     <= words_d;
    end
  end

  assign mem_address    = addr_q;
  assign mem_chipselect = wr_q;
  assign mem_clken      = 1'b1;
  assign mem_write      = wr_q;
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = be_q;
  assign st_busy        = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign st_done        = (state_q == S_DONE);
  assign st_overrun     = overrun_q;
  assign st_wrapped     = wrapped_q;
  assign st_words       = words_q;

endmodule

// File: tb/tb_nco_capture_writer.sv
// Scoreboard bench for nco_capture_writer: three instances cover a 2x32-bit
// config (A), a 1x16-bit config (B) and a 2x36-bit config (C).
module tb_nco_capture_writer;
  localparam int AW = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [63:0]   data;
    logic [7:0]    be;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cfg_arm, cfg_stop, cfg_trig_imm, cfg_continuous, trig_in;
  logic valid_a, valid_b, valid_c;
  logic [63:0] data_a;
  logic [15:0] data_b;
  logic [71:0] data_c;

  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic a_cs, b_cs, c_cs, a_ck, b_ck, c_ck, a_wr, b_wr, c_wr;
  logic [63:0] a_wd, b_wd, c_wd;
  logic [7:0] a_be, b_be, c_be;
  logic a_busy, b_busy, c_busy, a_done, b_done, c_done;
  logic a_ovr, b_ovr, c_ovr, a_wrap, b_wrap, c_wrap;
  logic [AW:0] a_words, b_words, c_words;

  int vectors = 0;
  int miscompares = 0;
  wr_t exp_a[$], exp_b[$], exp_c[$];
  wr_t wa, wb, wc;

  nco_capture_writer #(.NUM_CH(2), .SAMPLE_W(32), .ADDR_W(AW), .CAP_WORDS(4)) u_a (
    .clk_clk(clk), .reset_reset(rst), .in_data(data_a), .in_valid(valid_a),
    .cfg_arm(cfg_arm), .cfg_stop(cfg_stop), .cfg_trig_imm(cfg_trig_imm),
    .cfg_continuous(cfg_continuous), .trig_in(trig_in),
    .mem_address(a_addr), .mem_chipselect(a_cs), .mem_clken(a_ck), .mem_write(a_wr),
    .mem_writedata(a_wd), .mem_byteenable(a_be), .st_busy(a_busy), .st_done(a_done),
    .st_overrun(a_ovr), .st_wrapped(a_wrap), .st_words(a_words));

  nco_capture_writer #(.NUM_CH(1), .SAMPLE_W(16), .ADDR_W(AW), .CAP_WORDS(8)) u_b (
    .clk_clk(clk), .reset_reset(rst), .in_data(data_b), .in_valid(valid_b),
    .cfg_arm(cfg_arm), .cfg_stop(cfg_stop), .cfg_trig_imm(cfg_trig_imm),
    .cfg_continuous(cfg_continuous), .trig_in(trig_in),
    .mem_address(b_addr), .mem_chipselect(b_cs), .mem_clken(b_ck), .mem_write(b_wr),
    .mem_writedata(b_wd), .mem_byteenable(b_be), .st_busy(b_busy), .st_done(b_done),
    .st_overrun(b_ovr), .st_wrapped(b_wrap), .st_words(b_words));

  nco_capture_writer #(.NUM_CH(2), .SAMPLE_W(36), .ADDR_W(AW), .CAP_WORDS(4)) u_c (
    .clk_clk(clk), .reset_reset(rst), .in_data(data_c), .in_valid(valid_c),
    .cfg_arm(cfg_arm), .cfg_stop(cfg_stop), .cfg_trig_imm(cfg_trig_imm),
    .cfg_continuous(cfg_continuous), .trig_in(trig_in),
    .mem_address(c_addr), .mem_chipselect(c_cs), .mem_clken(c_ck), .mem_write(c_wr),
    .mem_writedata(c_wd), .mem_byteenable(c_be), .st_busy(c_busy), .st_done(c_done),
    .st_overrun(c_ovr), .st_wrapped(c_wrap), .st_words(c_words));

  // Write monitors: every strobe seen on the falling edge is popped against the scoreboard.
  always @(negedge clk) begin
    if (a_wr === 1'b1) begin
      vectors++;
      if (exp_a.size() == 0) begin
        miscompares++;
        $display("FAIL a_write: got unexpected addr=%0h data=%h be=%h, required none", a_addr, a_wd, a_be);
      end else begin
        wa = exp_a.pop_front();
        if ({a_addr, a_wd, a_be} !== wa || a_cs !== 1'b1) begin
          miscompares++;
          $display("FAIL a_write: got addr=%0h data=%h be=%h cs=%b, required addr=%0h data=%h be=%h cs=1",
                   a_addr, a_wd, a_be, a_cs, wa.addr, wa.data, wa.be);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_wr === 1'b1) begin
      vectors++;
      if (exp_b.size() == 0) begin
        miscompares++;
        $display("FAIL b_write: got unexpected addr=%0h data=%h be=%h, required none", b_addr, b_wd, b_be);
      end else begin
        wb = exp_b.pop_front();
        if ({b_addr, b_wd, b_be} !== wb || b_cs !== 1'b1) begin
          miscompares++;
          $display("FAIL b_write: got addr=%0h data=%h be=%h cs=%b, required addr=%0h data=%h be=%h cs=1",
                   b_addr, b_wd, b_be, b_cs, wb.addr, wb.data, wb.be);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (c_wr === 1'b1) begin
      vectors++;
      if (exp_c.size() == 0) begin
        miscompares++;
        $display("FAIL c_write: got unexpected addr=%0h data=%h be=%h, required none", c_addr, c_wd, c_be);
      end else begin
        wc = exp_c.pop_front();
        if ({c_addr, c_wd, c_be} !== wc || c_cs !== 1'b1) begin
          miscompares++;
          $display("FAIL c_write: got addr=%0h data=%h be=%h cs=%b, required addr=%0h data=%h be=%h cs=1",
                   c_addr, c_wd, c_be, c_cs, wc.addr, wc.data, wc.be);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic imm, input logic cont);
    cfg_trig_imm   = imm;
    cfg_continuous = cont;
    cfg_arm        = 1'b1;
    tick();
    cfg_arm        = 1'b0;
  endtask

  task automatic stop();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
  endtask

  // Wait (bounded) for all expected writes, then idle a few cycles so stray writes surface.
  task automatic drain(input string name);
    int budget = 40;
    while ((exp_a.size() + exp_b.size() + exp_c.size()) != 0 && budget > 0) begin
      tick();
      budget--;
    end
    vectors++;
    if ((exp_a.size() + exp_b.size() + exp_c.size()) != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d writes still outstanding, required 0", name,
               exp_a.size() + exp_b.size() + exp_c.size());
      exp_a.delete(); exp_b.delete(); exp_c.delete();
    end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    vectors++;
    if ({a_wr, a_cs, a_ck, a_busy, a_done, a_ovr, a_wrap} !== 7'b0010000) begin
      miscompares++;
      $display("FAIL reset_ctl: got wr,cs,clken,busy,done,ovr,wrap=%b, required 0010000",
               {a_wr, a_cs, a_ck, a_busy, a_done, a_ovr, a_wrap});
    end
    vectors++;
    if ({a_addr, a_wd, a_be, a_words} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got addr=%0h data=%h be=%h words=%0d, required all 0", a_addr, a_wd, a_be, a_words);
    end
    vectors++;
    if ({b_wr, b_ck, c_wr, c_ck} !== 4'b0101) begin
      miscompares++;
      $display("FAIL reset_bc: got b_wr,b_clken,c_wr,c_clken=%b, required 0101", {b_wr, b_ck, c_wr, c_ck});
    end
  endtask

  task automatic test_single_pair();
    arm(1'b1, 1'b0);
    data_a = {32'h0000_0002, 32'h0000_0001};
    exp_a.push_back('{addr: 4'd0, data: 64'h00000002_00000001, be: 8'hFF});
    valid_a = 1'b1; tick(); valid_a = 1'b0;
    drain("single_pair");
    vectors++;
    if ({a_words, a_busy, a_ovr} !== {5'd1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_status: got words=%0d busy=%b ovr=%b, required words=1 busy=1 ovr=0", a_words, a_busy, a_ovr);
    end
    stop();
    vectors++;
    if ({a_done, a_busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_stop: got done=%b busy=%b, required done=1 busy=0", a_done, a_busy);
    end
  endtask

  task automatic test_sext_flush();
    arm(1'b1, 1'b0);
    exp_b.push_back('{addr: 4'd0, data: 64'h00000001_FFFF8000, be: 8'hFF});
    valid_b = 1'b1;
    data_b = 16'h8000; tick();
    data_b = 16'h0001; tick();
    valid_b = 1'b0;
    drain("sext");
    data_b = 16'h1234; valid_b = 1'b1; tick(); valid_b = 1'b0;
    tick(); tick();
    exp_b.push_back('{addr: 4'd1, data: 64'h00000000_00001234, be: 8'h0F});
    stop();
    drain("flush");
    vectors++;
    if ({b_words, b_done} !== {5'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL flush_status: got words=%0d done=%b, required words=2 done=1", b_words, b_done);
    end
  endtask

  task automatic test_upper_bits();
    arm(1'b1, 1'b0);
    data_c = {36'hA_BCDE_F012, 36'h9_8765_4321};
    exp_c.push_back('{addr: 4'd0, data: 64'hABCDEF01_98765432, be: 8'hFF});
    valid_c = 1'b1; tick(); valid_c = 1'b0;
    drain("upper");
    stop();
  endtask

  task automatic test_oneshot_overrun();
    arm(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      data_a = {32'h1000 + 32'(i * 16) + 32'h1, 32'h1000 + 32'(i * 16)};
      // Back-to-back beats: only every other one finds the serialiser free, and
      // the ring holds four words before the one-shot capture ends.
      if (i % 2 == 0 && i < 8) exp_a.push_back('{addr: AW'(i / 2), data: data_a, be: 8'hFF});
      valid_a = 1'b1;
      tick();
    end
    valid_a = 1'b0;
    drain("oneshot");
    vectors++;
    if ({a_ovr, a_done, a_busy, a_wrap, a_words} !== {4'b1100, 5'd4}) begin
      miscompares++;
      $display("FAIL oneshot_status: got ovr=%b done=%b busy=%b wrap=%b words=%0d, required 1 1 0 0 4",
               a_ovr, a_done, a_busy, a_wrap, a_words);
    end
    stop();
  endtask

  task automatic test_continuous_wrap();
    arm(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      data_a = {32'hC000_0000 + 32'(2 * i + 1), 32'hC000_0000 + 32'(2 * i)};
      exp_a.push_back('{addr: AW'(i % 4), data: data_a, be: 8'hFF});
      valid_a = 1'b1; tick();
      valid_a = 1'b0; tick();
    end
    drain("wrap");
    vectors++;
    if ({a_wrap, a_ovr, a_busy, a_words} !== {3'b101, 5'd4}) begin
      miscompares++;
      $display("FAIL wrap_status: got wrap=%b ovr=%b busy=%b words=%0d, required 1 0 1 4", a_wrap, a_ovr, a_busy, a_words);
    end
    stop();
    vectors++;
    if (a_done !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_stop: got done=%b, required 1", a_done);
    end
  endtask

  task automatic test_trigger_edge();
    trig_in = 1'b1;
    tick();
    arm(1'b0, 1'b0);
    data_a = 64'hDEAD_0000_BEEF_0000;
    valid_a = 1'b1;
    repeat (3) tick();
    valid_a = 1'b0;
    tick();
    vectors++;
    if ({a_busy, a_words, a_ovr} !== {1'b1, 5'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL trig_held: got busy=%b words=%0d ovr=%b, required busy=1 words=0 ovr=0", a_busy, a_words, a_ovr);
    end
    trig_in = 1'b0; tick();
    trig_in = 1'b1; valid_a = 1'b1; data_a = 64'h1111_1111_2222_2222; tick();
    data_a = {32'h0000_00B2, 32'h0000_00B1};
    exp_a.push_back('{addr: 4'd0, data: 64'h000000B2_000000B1, be: 8'hFF});
    tick();
    valid_a = 1'b0;
    drain("trig");
    vectors++;
    if ({a_words, a_ovr} !== {5'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL trig_status: got words=%0d ovr=%b, required words=1 ovr=0", a_words, a_ovr);
    end
    trig_in = 1'b0;
    stop();
  endtask

  task automatic test_reset_mid_capture();
    arm(1'b1, 1'b0);
    data_a = 64'h5555_5555_4444_4444;
    valid_a = 1'b1; tick(); valid_a = 1'b0;
    tick(); tick();
    // The word's strobe has just risen; reset must pull it down at once.
    rst = 1'b1;
    #1;
    vectors++;
    if ({a_wr, a_cs, a_ck, a_busy, a_done, a_words} !== {5'b00100, 5'd0}) begin
      miscompares++;
      $display("FAIL reset_mid: got wr=%b cs=%b clken=%b busy=%b done=%b words=%0d, required 0 0 1 0 0 0",
               a_wr, a_cs, a_ck, a_busy, a_done, a_words);
    end
    tick(); tick();
    rst = 1'b0;
    repeat (4) tick();
    vectors++;
    if ({a_busy, a_done, a_wr} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%b done=%b wr=%b, required 000", a_busy, a_done, a_wr);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_arm = 1'b0; cfg_stop = 1'b0; cfg_trig_imm = 1'b0;
    cfg_continuous = 1'b0; trig_in = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    data_a = '0; data_b = '0; data_c = '0;
    #2;
    test_reset();
    tick(); tick();
    rst = 1'b0;
    tick();
    test_single_pair();
    test_sext_flush();
    test_upper_bits();
    test_oneshot_overrun();
    test_continuous_wrap();
    test_trigger_edge();
    test_reset_mid_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
